// File: rtl/vs_input_ctrl_pkg.sv
// vs_input_pkg: shared definitions for the VS System input controller.
//   BTN_*      : bit positions inside a pad byte {Right,Left,Down,Up,Start,Select,B,A}
//   pad_t      : one pad's button byte, 1 = pressed
//   coin_st_t  : coin conditioning FSM states
//   cnt_w()    : counter width for a terminal count, never narrower than 1 bit
package vs_input_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] pad_t;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } coin_st_t;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vs_input_ctrl_if.sv
// vs_input_ctrl_if: CPU-facing pad bus of the input controller.
//   strobe           : OUT[0], 1 = load pad shifters
//   nIN              : {nR4017,nR4016}, active-low read strobes
//   controller1_data : serial pad 1 bit, 1 = pressed
//   controller2_data : serial pad 2 bit, 1 = pressed
// master = CPU side, slave = vs_input_ctrl side.
interface vs_input_ctrl_if;
  logic       strobe;
  logic [1:0] nIN;
  logic       controller1_data;
  logic       controller2_data;

  modport master (
    output strobe,
    output nIN,
    input  controller1_data,
    input  controller2_data
  );

  modport slave (
    input  strobe,
    input  nIN,
    output controller1_data,
    output controller2_data
  );
endinterface

// File: rtl/vs_input_ctrl_pad_shifter.sv
// vs_pad_shifter: 4021-style 8-bit parallel-in/serial-out pad shifter.
//   Clk    : system clock
//   nRES   : asynchronous active-low reset
//   strobe : 1 = load pad every cycle (output parks on A)
//   nrd    : active-low read strobe; its rising edge (end of read) shifts
//   pad    : parallel button byte, 1 = pressed
//   data   : serial output sr[0], 1 = pressed; reads 1 after 8 shifts
module vs_pad_shifter
  import vs_input_pkg::*;
(
  input  logic Clk,
  input  logic nRES,
  input  logic strobe,
  input  logic nrd,
  input  pad_t pad,
  output logic data
);

  pad_t sr;
  logic nrd_prev;
  logic shift_ev;

  assign shift_ev = ~nrd_prev & nrd;

  always_ff @(posedge Clk or negedge nRES) begin
    if (!nRES) begin
      sr       <= '1;
      nrd_prev <= 1'b1;
    end else begin
      nrd_prev <= nrd;
      if (strobe)
        sr <= pad;
      else if (shift_ev)
        sr <= {1'b1, sr[7:1]};
    end
  end

  assign data = sr[0];

endmodule

// File: rtl/vs_input_ctrl.sv
// vs_input_ctrl: VS System input stage feeding $4016/$4017.
//   Clk, nRES              : system clock, async active-low reset
//   bus (slave)            : strobe, nIN, controller1_data, controller2_data
//   joy1, joy2             : pad buttons {Right,Left,Down,Up,Start,Select,B,A}
//   turbo1, turbo2         : {turboB,turboA} enables
//   coin1_btn, coin2_btn   : raw coin button levels
//   service_btn            : raw service button level
//   coin1, coin2           : fixed-width coin pulses (COIN_PULSE_CYCLES)
//   service                : registered service_btn
// Build option: define VS_TURBO_EN to add turbo autofire on A/B; otherwise
// turbo1/turbo2 are ignored and no turbo counter exists.
module vs_input_ctrl
  import vs_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 2147727,
  parameter int TURBO_HALF_CYCLES = 357955
) (
  input  logic            Clk,
  input  logic            nRES,
  vs_input_ctrl_if.slave  bus,
  input  pad_t            joy1,
  input  pad_t            joy2,
  input  logic [1:0]      turbo1,
  input  logic [1:0]      turbo2,
  input  logic            coin1_btn,
  input  logic            coin2_btn,
  input  logic            service_btn,
  output logic            coin1,
  output logic            coin2,
  output logic            service
);

  localparam int CW = cnt_w(COIN_PULSE_CYCLES);

  pad_t pad1, pad2;
  logic pad1_data, pad2_data;

`ifdef VS_TURBO_EN
  localparam int TW = cnt_w(TURBO_HALF_CYCLES);

  logic [TW-1:0] turbo_cnt;
  logic          turbo_phase;

  always_ff @(posedge Clk or negedge nRES) begin
    if (!nRES) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TW'(TURBO_HALF_CYCLES - 1)) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  always_comb begin
    pad1        = joy1;
    pad2        = joy2;
    pad1[BTN_A] = joy1[BTN_A] | (turbo1[0] & turbo_phase);
    pad1[BTN_B] = joy1[BTN_B] | (turbo1[1] & turbo_phase);
    pad2[BTN_A] = joy2[BTN_A] | (turbo2[0] & turbo_phase);
    pad2[BTN_B] = joy2[BTN_B] | (turbo2[1] & turbo_phase);
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^{turbo1, turbo2};
  assign pad1 = joy1;
  assign pad2 = joy2;
`endif

  vs_pad_shifter u_pad1 (
    .Clk    (Clk),
    .nRES   (nRES),
    .strobe (bus.strobe),
    .nrd    (bus.nIN[0]),
    .pad    (pad1),
    .data   (pad1_data)
  );

  vs_pad_shifter u_pad2 (
    .Clk    (Clk),
    .nRES   (nRES),
    .strobe (bus.strobe),
    .nrd    (bus.nIN[1]),
    .pad    (pad2),
    .data   (pad2_data)
  );

  assign bus.controller1_data = pad1_data;
  assign bus.controller2_data = pad2_data;

  logic [1:0] coin_btn;
  logic [1:0] coin_q;

  assign coin_btn = {coin2_btn, coin1_btn};

  for (genvar g = 0; g < 2; g++) begin : g_coin
    coin_st_t      st;
    logic [CW-1:0] cnt;
    logic          btn_prev;
    logic          armed;
    logic          pulse;

    // armed stays clear while a button is held through reset, so a coin
    // that was already down when reset released cannot fire until the
    // button has been seen released once.
    always_ff @(posedge Clk or negedge nRES) begin
      if (!nRES) begin
        st       <= IDLE;
        cnt      <= '0;
        btn_prev <= 1'b0;
        armed    <= 1'b0;
        pulse    <= 1'b0;
      end else begin
        btn_prev <= coin_btn[g];
        if (!coin_btn[g])
          armed <= 1'b1;
        case (st)
          IDLE: begin
            if (armed && coin_btn[g] && !btn_prev) begin
              st    <= PULSE;
              cnt   <= CW'(COIN_PULSE_CYCLES - 1);
              pulse <= 1'b1;
            end
          end
          PULSE: begin
            if (cnt == '0) begin
              st    <= HOLD;
              pulse <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HOLD: begin
            if (!coin_btn[g])
              st <= IDLE;
          end
          default: begin
            st    <= IDLE;
            pulse <= 1'b0;
          end
        endcase
      end
    end

    assign coin_q[g] = pulse;
  end

  assign coin1 = coin_q[0];
  assign coin2 = coin_q[1];

  always_ff @(posedge Clk or negedge nRES) begin
    if (!nRES)
      service <= 1'b0;
    else
      service <= service_btn;
  end

endmodule

// File: doc/vs_input_ctrl.md
Name: vs_input_ctrl

Overview:
- Upstream stage of nes_system's input path. It produces the controller1_data, controller2_data, coin1, coin2 and service inputs that the CPU reads through $4016 and $4017.
- It emulates two 4021-style 8-bit parallel-in/serial-out pad shifters. They load on the CPU strobe (OUT[0]) and advance on the end of each $4016/$4017 read (nIN[0] and nIN[1]).
- It converts raw coin button levels into fixed-width coin pulses, as a coin mechanism would produce.

Parameters:
- COIN_PULSE_CYCLES, 2147727: width of a coin pulse in Clk cycles (about 100 ms at 21.477 MHz).
- TURBO_HALF_CYCLES, 357955: half-period of the turbo square wave in Clk cycles (only used with VS_TURBO_EN).

Ports:
- Clk  in  1  system clock, shared with nes_system.
- nRES  in  1  asynchronous active-low reset.
- joy1  in  8  player 1 buttons, 1 = pressed, order {Right,Left,Down,Up,Start,Select,B,A}.
- joy2  in  8  player 2 buttons, same order as joy1.
- turbo1  in  2  player 1 {turboB,turboA} enables (used only with VS_TURBO_EN).
- turbo2  in  2  player 2 {turboB,turboA} enables (used only with VS_TURBO_EN).
- strobe  in  1  OUT[0] from the CPU.
- nIN  in  2  {nR4017,nR4016} from the CPU, active low.
- coin1_btn  in  1  raw coin 1 button level.
- coin2_btn  in  1  raw coin 2 button level.
- service_btn  in  1  raw service button level.
- controller1_data  out  1  serial pad 1 bit, 1 = pressed.
- controller2_data  out  1  serial pad 2 bit, 1 = pressed.
- coin1  out  1  conditioned coin 1 pulse.
- coin2  out  1  conditioned coin 2 pulse.
- service  out  1  registered service_btn.

Behaviour:
- Reset (async assert, sync release):
  - Shift registers are 8'hFF, so both data outputs read 1.
  - Coin FSMs go to IDLE; coin1, coin2 and service are 0.
  - Edge-detect flops are preset to 1 (nIN) and 0 (buttons).
  - The turbo phase is 0.
- Pad shifter (one per player, identical):
  - While strobe is 1, sr <= joy every cycle. The output is sr[0] (A) and never advances.
  - A strobe falling edge needs no action; sr holds the last loaded value.
  - The shift event is the rising edge of that player's nIN bit (end of read), detected as prev==0 && cur==1, registered.
  - On a shift event with strobe 0: sr <= {1'b1, sr[7:1]}. After 8 shifts the output reads 1 permanently until the next load.
  - If strobe is 1 and a shift event occurs in the same cycle, the load wins.
  - Output is combinational from sr[0], so data is valid the cycle after a load or shift, well before the next CPU read.
  - Read order is A, B, Select, Start, Up, Down, Left, Right, then 1s.
- Coin conditioning FSM, per coin:
  - IDLE: on a btn rising edge, go to PULSE, load the counter with COIN_PULSE_CYCLES-1, and set coin=1.
  - PULSE: decrement the counter. At 0, go to HOLD and set coin=0.
  - HOLD: wait for btn==0, then go to IDLE.
  - Holding the button produces exactly one pulse. A new edge during PULSE is ignored.
  - The counter width is $clog2(COIN_PULSE_CYCLES).
- service <= service_btn, one-cycle registered with no pulse shaping.
- Reset mid-pulse forces coin=0 immediately and returns the FSM to IDLE.

Optional Feature:
- VS_TURBO_EN defined:
  - A free-running counter toggles a turbo phase every TURBO_HALF_CYCLES.
  - The effective A bit for player n is joyn[0] | (turbon[0] & phase); B is handled the same way with bit 1.
  - The effective bits feed the shift-register load.
- VS_TURBO_EN undefined:
  - turbo1 and turbo2 are ignored, and no counter is synthesised.
  - joy loads directly.

Decomposition:
- Package vs_input_pkg holds:
  - button bit index localparams BTN_A=0 through BTN_RIGHT=7;
  - typedef pad_t (logic [7:0]);
  - the coin FSM state enum coin_st_t {IDLE, PULSE, HOLD}.
- Sub-module vs_pad_shifter (Clk, nRES, strobe, nrd, pad, data) is instantiated twice. The coin FSM is a generate loop over two instances inside the top level.

Test Plan:
- Reset release with joy1=8'h00 -> controller1_data=1; coin1=0; coin2=0.
- joy1=8'b0000_0101 (A + Select), strobe 1->0, then 10 nIN[0] low-high pulses -> sampled bits 1,0,1,0,0,0,0,0,1,1.
- strobe held 1, joy2=8'h01, 3 nIN[1] pulses -> controller2_data stays 1 (no advance); set joy2=8'h00 -> output 0 the next cycle.
- COIN_PULSE_CYCLES=16, coin1_btn held high for 100 cycles -> coin1 high for exactly 16 cycles, once. A second press after release -> a second 16-cycle pulse.
- nRES asserted at cycle 5 of a coin pulse -> coin1=0 asynchronously; after release with the button still high -> no pulse until the button is released and pressed again.
- VS_TURBO_EN, TURBO_HALF_CYCLES=8, turbo1=2'b01, joy1=0 -> reloading via strobe every cycle gives controller1_data alternating 8 cycles 0 and 8 cycles 1.
